// File: rtl/dft_pkg.sv
// Shared definitions for the sliding-DFT octave datapath: sequencer states,
// operation codes and the default octave/bin geometry.
package dft_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        SUB   = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int DFT_OCT  = 5;
    localparam int DFT_BINS = 24;
    localparam int DFT_OCW  = 8;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/octave_scheduler_if.sv
// Sample handshake and datapath-control bundle between the sample source,
// the octave scheduler and the trig-table/MAC datapath.
interface octave_scheduler_if #(
    parameter int OCT  = 5,
    parameter int BINS = 24,
    parameter int OCW  = 8
);
    import dft_pkg::*;

    localparam int OW = idx_width(OCT);
    localparam int BW = idx_width(BINS);

    logic            sampleReady;
    logic            sampleAccept;
    logic            writeSample;
    logic [OCT-1:0]  enableOctaves;
    logic [OW-1:0]   octave;
    logic [BW-1:0]   bin;
    logic            operation;
    logic            doCalculations;
    logic            finishedProcessing;
    logic            busy;
    logic [OCW-1:0]  overrunCount;

    modport master (
        output sampleReady,
        input  sampleAccept, writeSample, enableOctaves, octave, bin, operation,
        input  doCalculations, finishedProcessing, busy, overrunCount
    );

    modport slave (
        input  sampleReady,
        output sampleAccept, writeSample, enableOctaves, octave, bin, operation,
        output doCalculations, finishedProcessing, busy, overrunCount
    );

endinterface

// File: rtl/octave_decimator.sv
// Sample counter and octave-enable mask: octave k runs on every 2^k-th sample,
// matching the decimated sample storage.
module octave_decimator
    import dft_pkg::*;
#(
    parameter int OCT = DFT_OCT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           advance,
    input  logic           latch,
    output logic [OCT-1:0] enableOctaves
);

    localparam int IW = OCT - 1;

    logic [IW-1:0]  idx_r;
    logic [OCT-1:0] mask_r;

    // Octave k is enabled when the low k index bits are all ones.
    function automatic logic [OCT-1:0] octave_mask(input logic [IW-1:0] idx);
        logic [OCT-1:0] m;
        m = {{(OCT-1){1'b0}}, 1'b1};
        for (int k = 1; k < OCT; k++) begin
            m[k] = m[k-1] & idx[k-1];
        end
        return m;
    endfunction

    // Sample index and mask; mask is taken at accept so it is valid during WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r  <= {IW{1'b0}};
            mask_r <= {OCT{1'b0}};
        end else begin
            if (latch) begin
                mask_r <= octave_mask(idx_r);
            end
            if (advance) begin
                idx_r <= idx_r + IW'(1'b1);
            end
        end
    end

    assign enableOctaves = mask_r;

endmodule

// File: rtl/octave_scheduler.sv
// Merged octave sequencer: per sample, WRITE then SUB/ADD bin sweeps over each
// enabled octave, then DONE. Optional overrun counter under DFT_OVERRUN_COUNT_EN.
module octave_scheduler
    import dft_pkg::*;
#(
    parameter int OCT  = DFT_OCT,
    parameter int BINS = DFT_BINS,
    parameter int OCW  = DFT_OCW
) (
    input  logic                clk,
    input  logic                rst,
    octave_scheduler_if.slave   bus
);

    localparam int OW = idx_width(OCT);
    localparam int BW = idx_width(BINS);
    localparam logic [BW-1:0] BIN_LAST = BW'(BINS - 1);

    sched_state_t   state_r;
    logic [OW-1:0]  octave_r;
    logic [BW-1:0]  bin_r;
    logic           op_r;
    logic           write_r;
    logic           calc_r;
    logic           fin_r;
    logic           busy_r;
    logic           accept_s;
    logic           next_found_s;
    logic [OW-1:0]  next_octave_s;
    logic [OCT-1:0] mask_s;

    // Accept is gated by reset so every output reads 0 while rst is low.
    assign accept_s = rst && (state_r == IDLE) && bus.sampleReady;

    octave_decimator #(.OCT(OCT)) u_decimator (
        .clk           (clk),
        .rst           (rst),
        .advance       (state_r == DONE),
        .latch         (accept_s),
        .enableOctaves (mask_s)
    );

    // Lowest enabled octave above the current one; descending scan keeps the lowest.
    always_comb begin
        next_found_s  = 1'b0;
        next_octave_s = octave_r;
        for (int k = OCT - 1; k >= 0; k--) begin
            if ((k > int'(octave_r)) && mask_s[k]) begin
                next_found_s  = 1'b1;
                next_octave_s = OW'(k);
            end else begin
                next_found_s  = next_found_s;
            end
        end
    end

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            octave_r <= {OW{1'b0}};
            bin_r    <= {BW{1'b0}};
            op_r     <= OP_SUB;
            write_r  <= 1'b0;
            calc_r   <= 1'b0;
            fin_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.sampleReady) begin
                        state_r <= WRITE;
                        write_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                WRITE: begin
                    state_r  <= SUB;
                    write_r  <= 1'b0;
                    calc_r   <= 1'b1;
                    op_r     <= OP_SUB;
                    octave_r <= {OW{1'b0}};
                    bin_r    <= {BW{1'b0}};
                end
                SUB: begin
                    if (bin_r == BIN_LAST) begin
                        bin_r   <= {BW{1'b0}};
                        op_r    <= OP_ADD;
                        state_r <= ADD;
                    end else begin
                        bin_r <= bin_r + BW'(1'b1);
                    end
                end
                ADD: begin
                    if (bin_r == BIN_LAST) begin
                        bin_r <= {BW{1'b0}};
                        if (next_found_s) begin
                            octave_r <= next_octave_s;
                            op_r     <= OP_SUB;
                            state_r  <= SUB;
                        end else begin
                            calc_r  <= 1'b0;
                            fin_r   <= 1'b1;
                            state_r <= DONE;
                        end
                    end else begin
                        bin_r <= bin_r + BW'(1'b1);
                    end
                end
                DONE: begin
                    fin_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    write_r <= 1'b0;
                    calc_r  <= 1'b0;
                    fin_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DFT_OVERRUN_COUNT_EN
    logic [OCW-1:0] overrun_r;
    logic           dropped_s;

    assign dropped_s = bus.sampleReady && (state_r != IDLE);

    // Saturating count of strobes that arrived while a sample was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= {OCW{1'b0}};
        end else if (dropped_s && (overrun_r != {OCW{1'b1}})) begin
            overrun_r <= overrun_r + OCW'(1'b1);
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.overrunCount = overrun_r;
`else
    assign bus.overrunCount = {OCW{1'b0}};
`endif

    assign bus.sampleAccept       = accept_s;
    assign bus.writeSample        = write_r;
    assign bus.enableOctaves      = mask_s;
    assign bus.octave             = octave_r;
    assign bus.bin                = bin_r;
    assign bus.operation          = op_r;
    assign bus.doCalculations     = calc_r;
    assign bus.finishedProcessing = fin_r;
    assign bus.busy               = busy_r;

endmodule

// File: tb/tb_octave_scheduler.sv
// Scoreboard bench for octave_scheduler: stimulus predicts accept/mask/beat/done
// events from the octave schedule rules; a negedge monitor pops and compares.
module tb_octave_scheduler;
    import dft_pkg::*;

    localparam int OCT  = DFT_OCT;
    localparam int BINS = DFT_BINS;
    localparam int OCW  = 2;
    localparam int IDXN = 1 << (OCT - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    int acc_q[$];
    int mask_q[$];
    int calc_q[$];
    int done_q[$];

    int idx_m   = 0;
    int free_m  = 0;
    int last_m  = -1;
    int drops_m = 0;
    int mon_mask = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    octave_scheduler_if #(.OCT(OCT), .BINS(BINS), .OCW(OCW)) bus ();

    octave_scheduler #(.OCT(OCT), .BINS(BINS), .OCW(OCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_mask(input int idx);
        int m = 0;
        for (int k = 0; k < OCT; k++)
            if (((idx + 1) % (1 << k)) == 0) m |= (1 << k);
        return m;
    endfunction

    function automatic int popcount(input int v);
        int n = 0;
        for (int k = 0; k < 32; k++) n += (v >> k) & 1;
        return n;
    endfunction

    function automatic int exp_overrun();
`ifdef DFT_OVERRUN_COUNT_EN
        return drops_m;
`else
        return 0;
`endif
    endfunction

    task automatic strobe();
        int mask, lat;
        @(posedge clk);
        #1;
        bus.sampleReady = 1'b1;
        if (cyc >= free_m) begin
            mask = model_mask(idx_m);
            lat  = 2 + 2 * BINS * popcount(mask);
            acc_q.push_back(1);
            mask_q.push_back(mask);
            for (int k = 0; k < OCT; k++)
                if (mask[k])
                    for (int op = 0; op < 2; op++)
                        for (int b = 0; b < BINS; b++)
                            calc_q.push_back(k * 256 + b * 2 + op);
            done_q.push_back(cyc + lat);
            last_m = cyc;
            free_m = cyc + lat + 1;
            idx_m  = (idx_m + 1) % IDXN;
        end else begin
            acc_q.push_back(0);
            if (drops_m < (1 << OCW) - 1) drops_m++;
        end
        @(posedge clk);
        #1;
        bus.sampleReady = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_accept"}, int'(bus.sampleAccept), 0);
        check({tag, "_write"},  int'(bus.writeSample), 0);
        check({tag, "_mask"},   int'(bus.enableOctaves), 0);
        check({tag, "_octave"}, int'(bus.octave), 0);
        check({tag, "_bin"},    int'(bus.bin), 0);
        check({tag, "_op"},     int'(bus.operation), 0);
        check({tag, "_calc"},   int'(bus.doCalculations), 0);
        check({tag, "_fin"},    int'(bus.finishedProcessing), 0);
        check({tag, "_busy"},   int'(bus.busy), 0);
        check({tag, "_ovr"},    int'(bus.overrunCount), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.sampleReady = 1'($urandom);
        #1;
        check_all_zero("reset_async");
        acc_q.delete(); mask_q.delete(); calc_q.delete(); done_q.delete();
        idx_m = 0; free_m = 0; last_m = -1; drops_m = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.sampleReady = 1'($urandom);
        end
        #1;
        check_all_zero("reset_hold");
        bus.sampleReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs to queued predictions away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.sampleReady) begin
                if (acc_q.size() > 0) check("sampleAccept", int'(bus.sampleAccept), acc_q.pop_front());
                else check("sampleAccept_spurious", int'(bus.sampleAccept), 0);
            end else begin
                check("sampleAccept_idle", int'(bus.sampleAccept), 0);
            end
            check("busy", int'(bus.busy), int'(cyc > last_m && cyc < free_m));
            if (bus.writeSample) begin
                if (mask_q.size() > 0) begin
                    mon_mask = mask_q.pop_front();
                    check("write_mask", int'(bus.enableOctaves), mon_mask);
                end else check("write_unexpected", int'(bus.writeSample), 0);
            end
            if (bus.doCalculations) begin
                if (calc_q.size() > 0)
                    check("beat", int'(bus.octave) * 256 + int'(bus.bin) * 2 + int'(bus.operation),
                          calc_q.pop_front());
                else check("calc_unexpected", int'(bus.doCalculations), 0);
            end
            if (bus.finishedProcessing) begin
                check("mask_stable", int'(bus.enableOctaves), mon_mask);
                if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
                else check("done_unexpected", int'(bus.finishedProcessing), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sampleReady = 1'b0;
        do_reset();

        // Single sample, then a strobe dropped mid-SUB, then idx 1.
        strobe();
        repeat (10) @(posedge clk);
        strobe();
        repeat (60) @(posedge clk);
        check("overrun_single", int'(bus.overrunCount), exp_overrun());
        strobe();
        repeat (110) @(posedge clk);

        // Full 16-sample mask cycle.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            strobe();
            repeat (298) @(posedge clk);
        end

        // Burst of dropped strobes to reach saturation.
        strobe();
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(posedge clk);
            strobe();
        end
        repeat (300) @(posedge clk);
        check("overrun_sat", int'(bus.overrunCount), exp_overrun());

        // Reset in the middle of octave 2 ADD on idx 3, then restart at idx 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            strobe();
            repeat (298) @(posedge clk);
        end
        strobe();
        repeat (128) @(posedge clk);
        do_reset();
        strobe();
        repeat (60) @(posedge clk);

        // Randomly spaced strobes, some landing while busy.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 120)) @(posedge clk);
            strobe();
        end
        repeat (400) @(posedge clk);

        check("calc_q_drained", calc_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("mask_q_drained", mask_q.size(), 0);
        check("overrun_final", int'(bus.overrunCount), exp_overrun());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
